relm_fifo_mio: RTL and testbench



---
 rtl/relm_fifo_mio.sv | 170 +++++++++++++++++
 tb/tb_relm_fifo_mio.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/relm_fifo_mio.sv
// relm_fifo_mio: multi-channel FIFO I/O peripheral for the ReLM PE ring.
//
// Provides NCH independent show-ahead FIFOs, each 2**WAD words deep and WD
// bits wide. Every channel has one push port and one pop port. Both ports use
// the ring's {strobe, data} (WD+1)-bit bus format.
//
// Ports:
//   clk        - clock; all state updates happen on the rising edge
//   rst_n      - asynchronous active-low reset; empties every channel
//   push_d     - per channel c, slice [c*(WD+1) +: WD+1]:
//                bit WD = push strobe, [WD-1:0] = data
//   push_retry - per channel: the push was not accepted; the PE must retry
//   pop_d      - per channel: bit WD = command strobe, [1:0] = command
//                (00 STATUS, 01 DATA, 10 PEEK, 11 FLUSH)
//   pop_q      - per channel: bit WD = retry, [WD-1:0] = result
//
// Build option:
//   RELM_FIFO_MIO_STATS_EN - adds a high-water register and a sticky overflow
//   flag per channel. Both are reported by STATUS and cleared by FLUSH.
//   Requires WD >= 2*WAD+3.
module relm_fifo_mio #(
  parameter int NCH = 2,
  parameter int WAD = 4,
  parameter int WD  = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH*(WD+1)-1:0] push_d,
  output logic [NCH-1:0]        push_retry,
  input  logic [NCH*(WD+1)-1:0] pop_d,
  output logic [NCH*(WD+1)-1:0] pop_q
);

  localparam int W     = WD + 1;
  localparam int DEPTH = 2 ** WAD;

  localparam logic [1:0] CMD_STATUS = 2'b00;
  localparam logic [1:0] CMD_DATA   = 2'b01;
  localparam logic [1:0] CMD_PEEK   = 2'b10;
  localparam logic [1:0] CMD_FLUSH  = 2'b11;

  localparam logic [WAD:0] FULL_CNT = (WAD+1)'(DEPTH);

  for (genvar c = 0; c < NCH; c++) begin : gCh
    logic          pushStb;
    logic [WD-1:0] pushData;
    logic          cmdStb;
    logic [1:0]    cmd;
    logic          unusedCmdBits;

    logic [WAD:0]  wptr_q, wptr_d;
    logic [WAD:0]  rptr_q, rptr_d;
    logic [WAD:0]  count_q, count_d;
    logic [WD-1:0] head_q, head_d;
    logic [WD-1:0] mem_q [DEPTH];

    logic          empty, full, deq, flush, retry, enq;
    logic [WAD:0]  countAfterDeq;
    logic [WD-1:0] statusWord;
    logic [WD:0]   popResp;

    assign pushStb       = push_d[c*W + WD];
    assign pushData      = push_d[c*W +: WD];
    assign cmdStb        = pop_d[c*W + WD];
    assign cmd           = pop_d[c*W +: 2];
    assign unusedCmdBits = ^pop_d[c*W + 2 +: WD-2];

    // Control decode and next-state.
    // head_q always holds the word at rptr so that the head is visible in the
    // cycle after its push. When the word written this cycle becomes the head
    // (nothing is left after any dequeue), it is bypassed straight into head_q.
    // Otherwise the head is prefetched from memory at the next read pointer.
    // That slot was written in an earlier cycle, so the read sees stable data.
    always_comb begin
      empty         = (count_q == '0);
      full          = (count_q == FULL_CNT);
      deq           = cmdStb && (cmd == CMD_DATA) && !empty;
      flush         = cmdStb && (cmd == CMD_FLUSH);
      retry         = pushStb && ((full && !deq) || flush);
      enq           = pushStb && !retry;
      countAfterDeq = count_q - (WAD+1)'(deq);
      wptr_d        = wptr_q + (WAD+1)'(enq);
      rptr_d        = flush ? wptr_q : rptr_q + (WAD+1)'(deq);
      count_d       = flush ? '0 : countAfterDeq + (WAD+1)'(enq);
      head_d        = (enq && (countAfterDeq == '0)) ? pushData
                                                     : mem_q[rptr_d[WAD-1:0]];
    end

    // The memory has no reset so that it can map onto a plain dual-port RAM.
    always_ff @(posedge clk) begin
      if (enq) begin
        mem_q[wptr_q[WAD-1:0]] <= pushData;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wptr_q  <= '0;
        rptr_q  <= '0;
        count_q <= '0;
        head_q  <= '0;
      end else begin
        wptr_q  <= wptr_d;
        rptr_q  <= rptr_d;
        count_q <= count_d;
        head_q  <= head_d;
      end
    end

`ifdef RELM_FIFO_MIO_STATS_EN
    if (WD < 2*WAD + 3) begin : gStatsWidthErr
      $error("relm_fifo_mio: RELM_FIFO_MIO_STATS_EN requires WD >= 2*WAD+3");
    end

    logic [WAD:0] hw_q, hw_d;
    logic         ovf_q, ovf_d;

    // The overflow flag records only retries caused by a full FIFO.
    // A flush resets both statistics.
    always_comb begin
      hw_d  = flush ? '0 : ((count_d > hw_q) ? count_d : hw_q);
      ovf_d = flush ? 1'b0 : (ovf_q || (pushStb && full && !deq));
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        hw_q  <= '0;
        ovf_q <= 1'b0;
      end else begin
        hw_q  <= hw_d;
        ovf_q <= ovf_d;
      end
    end

    always_comb begin
      statusWord                  = '0;
      statusWord[WAD:0]           = count_q;
      statusWord[2*WAD+1:WAD+1]   = hw_q;
      statusWord[WD-1]            = ovf_q;
    end
`else
    always_comb begin
      statusWord = {{(WD-WAD-1){1'b0}}, count_q};
    end
`endif

    // Same-cycle command response. It is built only from registered state,
    // so there is no path from push to pop within a cycle.
    always_comb begin
      popResp = '0;
      if (!cmdStb) begin
        popResp[0] = !empty;
      end else begin
        case (cmd)
          CMD_DATA:   popResp = empty ? {1'b1, {WD{1'b0}}} : {1'b0, head_q};
          CMD_STATUS: popResp = {1'b0, statusWord};
          CMD_PEEK:   popResp = {empty, (empty ? {WD{1'b0}} : head_q)};
          CMD_FLUSH:  popResp = {1'b0, {(WD-WAD-1){1'b0}}, count_q};
          default:    popResp = '0;
        endcase
      end
    end

    // Outputs are forced quiet while reset is asserted.
    // This holds even when strobes are active.
    assign pop_q[c*W +: W] = rst_n ? popResp : '0;
    assign push_retry[c]   = rst_n && retry;
  end

endmodule

// File: tb/tb_relm_fifo_mio.sv
// tb_relm_fifo_mio: self-checking bench for relm_fifo_mio (NCH=2, WAD=4, WD=32).
// The stimulus process queues the expected responses. A monitor on the
// falling clock edge pops each queued entry and compares it with the DUT.
// Expected STATUS words change when RELM_FIFO_MIO_STATS_EN is defined.
module tb_relm_fifo_mio;

  localparam int NCH = 2;
  localparam int WAD = 4;
  localparam int WD  = 32;
  localparam int W   = WD + 1;

  localparam logic [1:0] CMD_STATUS = 2'b00;
  localparam logic [1:0] CMD_DATA   = 2'b01;
  localparam logic [1:0] CMD_PEEK   = 2'b10;
  localparam logic [1:0] CMD_FLUSH  = 2'b11;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [NCH*W-1:0]    push_d = '0;
  logic [NCH-1:0]      push_retry;
  logic [NCH*W-1:0]    pop_d = '0;
  logic [NCH*W-1:0]    pop_q;

  typedef struct {
    string       name;
    int          ch;
    bit          isRetry;
    logic [WD:0] val;
  } exp_t;

  exp_t expQ[$];
  int   testsRun = 0;
  int   testsFailed = 0;

  relm_fifo_mio #(.NCH(NCH), .WAD(WAD), .WD(WD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_d     (push_d),
    .push_retry (push_retry),
    .pop_d      (pop_d),
    .pop_q      (pop_q)
  );

  always #5 clk = ~clk;

  // Drive one channel's push and pop ports for the current cycle.
  task automatic applyStimulus(input int ch, input bit ps, input logic [WD-1:0] pd,
                               input bit cs, input logic [1:0] cmd);
    push_d[ch*W +: W] = {ps, pd};
    pop_d[ch*W +: W]  = {cs, {(WD-2){1'b0}}, cmd};
  endtask

  task automatic idleAll();
    for (int ch = 0; ch < NCH; ch++) applyStimulus(ch, 1'b0, '0, 1'b0, CMD_STATUS);
  endtask

  task automatic expPop(input string n, input int ch, input bit r, input logic [WD-1:0] v);
    expQ.push_back('{n, ch, 1'b0, {r, v}});
  endtask

  task automatic expRetry(input string n, input int ch, input bit r);
    expQ.push_back('{n, ch, 1'b1, {{WD{1'b0}}, r}});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input exp_t e);
    logic [WD:0] act;
    act = e.isRetry ? {{WD{1'b0}}, push_retry[e.ch]} : pop_q[e.ch*W +: W];
    testsRun++;
    if (act !== e.val) begin
      testsFailed++;
      $display("[TB] FAIL %s ch%0d: got %h, expected %h", e.name, e.ch, act, e.val);
    end
  endtask

  // Monitor: compare everything queued for this cycle on the falling edge.
  always @(negedge clk) begin : monitor
    exp_t e;
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput(e);
    end
  end

  initial begin
    logic [WD-1:0] expStatus;
    idleAll();
    repeat (2) @(posedge clk);
    #1;

    // Outputs during reset stay zero even with active strobes.
    applyStimulus(0, 1'b1, 32'h77, 1'b1, CMD_DATA);
    expPop("pop in reset", 0, 1'b0, '0);
    expRetry("retry in reset", 0, 1'b0);
    tick();
    rst_n = 1'b1;
    idleAll();
    expPop("idle after reset", 0, 1'b0, '0);
    tick();

    // Fill ch0, push while full, then drain in order.
    for (int i = 0; i < 16; i++) begin
      applyStimulus(0, 1'b1, 32'h11 + i, 1'b0, CMD_STATUS);
      expRetry($sformatf("fill push %0d", i), 0, 1'b0);
      tick();
    end
    applyStimulus(0, 1'b1, 32'h99, 1'b1, CMD_STATUS);
    expRetry("push when full", 0, 1'b1);
    expPop("status full", 0, 1'b0, 32'd16);
    tick();
    for (int i = 0; i < 16; i++) begin
      applyStimulus(0, 1'b0, '0, 1'b1, CMD_DATA);
      expPop($sformatf("drain %0d", i), 0, 1'b0, 32'h11 + i);
      tick();
    end
    applyStimulus(0, 1'b0, '0, 1'b1, CMD_DATA);
    expPop("pop empty", 0, 1'b1, '0);
    expRetry("no strobe retry", 0, 1'b0);
    tick();

    // Reset mid-stream while ch0 holds 5 words.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 1'b1, 32'h31 + i, 1'b0, CMD_STATUS);
      tick();
    end
    applyStimulus(0, 1'b0, '0, 1'b1, CMD_STATUS);
    expPop("status before reset", 0, 1'b0, 32'd5);
    tick();
    rst_n = 1'b0;
    applyStimulus(0, 1'b1, 32'h55, 1'b1, CMD_DATA);
    expPop("pop mid reset", 0, 1'b0, '0);
    expRetry("retry mid reset", 0, 1'b0);
    tick();
    rst_n = 1'b1;
    idleAll();
    expPop("idle post reset", 0, 1'b0, '0);
    expRetry("retry post reset", 0, 1'b0);
    tick();
    applyStimulus(0, 1'b1, 32'h42, 1'b1, CMD_STATUS);
    expPop("status post reset", 0, 1'b0, '0);
    expRetry("first push post reset", 0, 1'b0);
    tick();
    applyStimulus(0, 1'b0, '0, 1'b1, CMD_DATA);
    expPop("pop post reset", 0, 1'b0, 32'h42);
    tick();

    // Push and DATA pop in the same cycle on an empty channel.
    applyStimulus(0, 1'b1, 32'h5, 1'b1, CMD_DATA);
    expPop("pop empty with push", 0, 1'b1, '0);
    expRetry("push empty with pop", 0, 1'b0);
    tick();
    applyStimulus(0, 1'b0, '0, 1'b1, CMD_PEEK);
    expPop("peek", 0, 1'b0, 32'h5);
    tick();
    applyStimulus(0, 1'b0, '0, 1'b1, CMD_STATUS);
    expPop("status one", 0, 1'b0, 32'd1);
    tick();
    applyStimulus(0, 1'b0, '0, 1'b1, CMD_DATA);
    expPop("pop one", 0, 1'b0, 32'h5);
    tick();
    applyStimulus(0, 1'b0, '0, 1'b1, CMD_STATUS);
    expPop("status zero", 0, 1'b0, '0);
    tick();
    idleAll();

    // ch1 full with a simultaneous push and DATA pop.
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1, 1'b1, 32'h101 + i, 1'b0, CMD_STATUS);
      tick();
    end
    applyStimulus(1, 1'b1, 32'hAA, 1'b1, CMD_DATA);
    expPop("full pop+push", 1, 1'b0, 32'h101);
    expRetry("full push with pop", 1, 1'b0);
    tick();
    applyStimulus(1, 1'b0, '0, 1'b1, CMD_STATUS);
    expPop("status after swap", 1, 1'b0, 32'd16);
    tick();
    for (int i = 0; i < 15; i++) begin
      applyStimulus(1, 1'b0, '0, 1'b1, CMD_DATA);
      expPop($sformatf("ch1 drain %0d", i), 1, 1'b0, 32'h102 + i);
      tick();
    end
    applyStimulus(1, 1'b0, '0, 1'b1, CMD_DATA);
    expPop("ch1 last is AA", 1, 1'b0, 32'hAA);
    tick();
    applyStimulus(1, 1'b0, '0, 1'b1, CMD_DATA);
    expPop("ch1 empty", 1, 1'b1, '0);
    tick();

    // FLUSH ch1 with a same-cycle push; ch0 must be unaffected.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 1'b1, 32'h201 + i, 1'b0, CMD_STATUS);
      if (i < 2) applyStimulus(0, 1'b1, 32'h301 + i, 1'b0, CMD_STATUS);
      else applyStimulus(0, 1'b0, '0, 1'b0, CMD_STATUS);
      tick();
    end
    applyStimulus(1, 1'b1, 32'h2FF, 1'b1, CMD_FLUSH);
    expPop("flush count", 1, 1'b0, 32'd3);
    expRetry("push during flush", 1, 1'b1);
    expPop("ch0 not empty", 0, 1'b0, 32'd1);
    tick();
    applyStimulus(1, 1'b0, '0, 1'b1, CMD_STATUS);
    applyStimulus(0, 1'b0, '0, 1'b1, CMD_STATUS);
    expPop("status after flush", 1, 1'b0, '0);
    expPop("ch0 status unaffected", 0, 1'b0, 32'd2);
    tick();
    applyStimulus(1, 1'b1, 32'h2AB, 1'b0, CMD_STATUS);
    applyStimulus(0, 1'b0, '0, 1'b1, CMD_DATA);
    expPop("ch0 pop after flush", 0, 1'b0, 32'h301);
    tick();
    applyStimulus(1, 1'b0, '0, 1'b1, CMD_PEEK);
    idleAll();
    applyStimulus(1, 1'b0, '0, 1'b1, CMD_PEEK);
    expPop("peek after flush", 1, 1'b0, 32'h2AB);
    tick();
    applyStimulus(1, 1'b0, '0, 1'b1, CMD_DATA);
    expPop("pop after flush", 1, 1'b0, 32'h2AB);
    tick();
    idleAll();

    // Statistics: flush ch0 to start clean, push 9, pop 4, then overfill.
    applyStimulus(0, 1'b0, '0, 1'b1, CMD_FLUSH);
    expPop("flush ch0", 0, 1'b0, 32'd1);
    tick();
    for (int i = 0; i < 9; i++) begin
      applyStimulus(0, 1'b1, 32'h401 + i, 1'b0, CMD_STATUS);
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1'b0, '0, 1'b1, CMD_DATA);
      expPop($sformatf("stats pop %0d", i), 0, 1'b0, 32'h401 + i);
      tick();
    end
`ifdef RELM_FIFO_MIO_STATS_EN
    expStatus = 32'h0000_0125;
`else
    expStatus = 32'd5;
`endif
    applyStimulus(0, 1'b0, '0, 1'b1, CMD_STATUS);
    expPop("status 9 in 4 out", 0, 1'b0, expStatus);
    tick();
    for (int i = 0; i < 11; i++) begin
      applyStimulus(0, 1'b1, 32'h501 + i, 1'b0, CMD_STATUS);
      tick();
    end
`ifdef RELM_FIFO_MIO_STATS_EN
    expStatus = 32'h0000_0210;
`else
    expStatus = 32'd16;
`endif
    applyStimulus(0, 1'b1, 32'h5FF, 1'b1, CMD_STATUS);
    expRetry("overfill retry", 0, 1'b1);
    expPop("status at overfill", 0, 1'b0, expStatus);
    tick();
`ifdef RELM_FIFO_MIO_STATS_EN
    expStatus = 32'h8000_0210;
`else
    expStatus = 32'd16;
`endif
    applyStimulus(0, 1'b0, '0, 1'b1, CMD_STATUS);
    expPop("status after overfill", 0, 1'b0, expStatus);
    tick();
    applyStimulus(0, 1'b0, '0, 1'b1, CMD_FLUSH);
    expPop("flush full", 0, 1'b0, 32'd16);
    tick();
    applyStimulus(0, 1'b0, '0, 1'b1, CMD_STATUS);
    expPop("status after stats flush", 0, 1'b0, '0);
    tick();

    idleAll();
    repeat (2) tick();
    testsRun++;
    if (expQ.size() != 0) begin
      testsFailed++;
      $display("[TB] FAIL scoreboard drain: got %0d pending, expected 0", expQ.size());
    end
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
